// File: rtl/recovery_restore_seq_if.sv
// Bus between the restore sequencer and its two storage ports: the
// recovery register read port and the architectural regfile write port.
interface recovery_restore_seq_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic [31:0]   rr_addr_o;  // recovery register read address
  logic [DW-1:0] rr_rd_i;    // recovery register read data (combinational)
  logic          rf_we_o;    // regfile write enable
  logic [AW-1:0] rf_addr_o;  // regfile write address
  logic [DW-1:0] rf_wd_o;    // regfile write data

  // Sequencer side
  modport master (
    output rr_addr_o, rf_we_o, rf_addr_o, rf_wd_o,
    input  rr_rd_i
  );

  // Storage side
  modport slave (
    input  rr_addr_o, rf_we_o, rf_addr_o, rf_wd_o,
    output rr_rd_i
  );
endinterface

// File: rtl/recovery_restore_seq.sv
// Rollback sequencer: after a voter fault edge, reads the checkpointed
// register image out of the recovery register file and replays it into the
// architectural regfile, one entry per cycle, while holding the pipeline.
module recovery_restore_seq #(
  parameter int NREGS   = 32,
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int SKIP_X0 = 1,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 fault_i,
  recovery_restore_seq_if.master bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_W-1:0]     restore_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  // x0 is hard-wired zero in the core, so by default it is skipped.
  localparam logic [AW-1:0]    START   = (SKIP_X0 != 0) ? AW'(1) : '0;
  localparam logic [AW-1:0]    LAST    = AW'(NREGS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            r_state;
  state_t            w_next;
  logic              r_fault_q;
  logic              w_trig;
  logic [AW-1:0]     r_rd_idx;
  logic [AW-1:0]     r_wr_idx;
  logic              r_wr_vld;
  logic [DW-1:0]     r_data_q;
  logic [CNT_W-1:0]  r_cnt;

  // Only a rising edge of the voter flag starts (or restarts) a restore.
  assign w_trig = fault_i & ~r_fault_q;

  // Write port is driven straight from registers; read address is the
  // zero-extended fetch index.
  assign bus.rr_addr_o  = 32'(r_rd_idx);
  assign bus.rf_we_o    = r_wr_vld;
  assign bus.rf_addr_o  = r_wr_idx;
  assign bus.rf_wd_o    = r_data_q;
  assign restore_cnt_o  = r_cnt;

  // State register.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every
      // register samples pre-edge values, independent of block order.
      r_state <= w_next;
    end
  end

  // Next-state decode plus the state-derived status outputs.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missed
    // branch would otherwise infer a latch.
    w_next = r_state;
    busy_o = 1'b1;
    done_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (w_trig) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (w_trig)                w_next = S_FETCH;
        else if (r_rd_idx == LAST) w_next = S_DRAIN;
      end
      S_DRAIN: w_next = w_trig ? S_FETCH : S_DONE;
      S_DONE: begin
        done_o = 1'b1;
        w_next = w_trig ? S_FETCH : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Fetch/write pipeline: one read per FETCH cycle, its write one cycle later.
  // A new fault edge drops the pending write and rewinds to the first entry.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_fault_q <= 1'b0;
      r_rd_idx  <= '0;
      r_wr_idx  <= '0;
      r_wr_vld  <= 1'b0;
      r_data_q  <= '0;
      r_cnt     <= '0;
    end else begin
      r_fault_q <= fault_i;
      case (r_state)
        S_IDLE: begin
          r_wr_vld <= 1'b0;
          r_rd_idx <= w_trig ? START : '0;
        end
        S_FETCH: begin
          if (w_trig) begin
            r_wr_vld <= 1'b0;
            r_rd_idx <= START;
          end else begin
            r_data_q <= bus.rr_rd_i;
            r_wr_idx <= r_rd_idx;
            r_wr_vld <= 1'b1;
            // Hold on the last entry so the index never wraps.
            if (r_rd_idx != LAST) r_rd_idx <= r_rd_idx + AW'(1);
          end
        end
        S_DRAIN: begin
          r_wr_vld <= 1'b0;
          if (w_trig) r_rd_idx <= START;
        end
        S_DONE: begin
          r_wr_vld <= 1'b0;
          r_rd_idx <= w_trig ? START : '0;
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
        end
        default: begin
          r_wr_vld <= 1'b0;
          r_rd_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_recovery_restore_seq.sv
// Directed bench for recovery_restore_seq: three instances cover the default
// configuration, x0 restore enabled, and a 2-bit saturating counter.
module tb_recovery_restore_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fault_a = 1'b0, fault_b = 1'b0, fault_c = 1'b0;
  logic busy_a, done_a, busy_b, done_b, busy_c, done_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic [31:0] mem [32];

  int n_checks = 0;
  int n_err    = 0;
  int pos_cnt  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) pos_cnt = pos_cnt + 1;

  recovery_restore_seq_if #(.AW(5), .DW(32)) if_a ();
  recovery_restore_seq_if #(.AW(5), .DW(32)) if_b ();
  recovery_restore_seq_if #(.AW(5), .DW(32)) if_c ();

  // Recovery register file model: combinational read.
  assign if_a.rr_rd_i = mem[if_a.rr_addr_o[4:0]];
  assign if_b.rr_rd_i = mem[if_b.rr_addr_o[4:0]];
  assign if_c.rr_rd_i = mem[if_c.rr_addr_o[4:0]];

  recovery_restore_seq #(.NREGS(32), .AW(5), .DW(32), .SKIP_X0(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst_in(rst_n), .fault_i(fault_a), .bus(if_a),
    .busy_o(busy_a), .done_o(done_a), .restore_cnt_o(cnt_a));
  recovery_restore_seq #(.NREGS(32), .AW(5), .DW(32), .SKIP_X0(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst_in(rst_n), .fault_i(fault_b), .bus(if_b),
    .busy_o(busy_b), .done_o(done_b), .restore_cnt_o(cnt_b));
  recovery_restore_seq #(.NREGS(32), .AW(5), .DW(32), .SKIP_X0(1), .CNT_W(2)) dut_c (
    .clk(clk), .rst_in(rst_n), .fault_i(fault_c), .bus(if_c),
    .busy_o(busy_c), .done_o(done_c), .restore_cnt_o(cnt_c));

  logic        we [3];
  logic [4:0]  wa [3];
  logic [31:0] wd [3];
  logic        bz [3];
  logic        dn [3];
  assign we[0] = if_a.rf_we_o;   assign wa[0] = if_a.rf_addr_o; assign wd[0] = if_a.rf_wd_o;
  assign we[1] = if_b.rf_we_o;   assign wa[1] = if_b.rf_addr_o; assign wd[1] = if_b.rf_wd_o;
  assign we[2] = if_c.rf_we_o;   assign wa[2] = if_c.rf_addr_o; assign wd[2] = if_c.rf_wd_o;
  assign bz[0] = busy_a; assign bz[1] = busy_b; assign bz[2] = busy_c;
  assign dn[0] = done_a; assign dn[1] = done_b; assign dn[2] = done_c;

  // Write/status log per instance. Sampled mid-cycle; a value seen here
  // lands on the next rising edge (pos_cnt+1).
  logic [4:0]  log_addr [3][64];
  logic [31:0] log_data [3][64];
  int          log_edge [3][64];
  int          wn [3];
  int          busy_n [3];
  int          done_n [3];
  int          done_edge [3];

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (we[d] === 1'b1 && wn[d] < 64) begin
        log_addr[d][wn[d]] = wa[d];
        log_data[d][wn[d]] = wd[d];
        log_edge[d][wn[d]] = pos_cnt + 1;
        wn[d] = wn[d] + 1;
      end
      if (bz[d] === 1'b1) busy_n[d] = busy_n[d] + 1;
      if (dn[d] === 1'b1) begin
        done_n[d]    = done_n[d] + 1;
        done_edge[d] = pos_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_log(input int d);
    wn[d] = 0; busy_n[d] = 0; done_n[d] = 0; done_edge[d] = 0;
  endtask

  task automatic set_fault(input int d, input logic v);
    case (d)
      0:       fault_a = v;
      1:       fault_b = v;
      default: fault_c = v;
    endcase
  endtask

  // Raise the fault at a negedge; returns the edge at which it is sampled.
  task automatic pulse_fault(input int d, output int t_edge);
    @(negedge clk);
    set_fault(d, 1'b1);
    t_edge = pos_cnt + 1;
    @(negedge clk);
    set_fault(d, 1'b0);
  endtask

  // Compare n logged writes starting at log index base against a pass
  // that begins at address a0 with its first write landing at edge e0.
  task automatic check_pass(input int d, input string tag, input int base,
                            input int a0, input int n, input int e0);
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, 64'(log_addr[d][base+i]), 64'(a0 + i));
      check({tag, "_data"}, 64'(log_data[d][base+i]), 64'(32'hA5A5_0000 + 32'(a0 + i)));
      check({tag, "_edge"}, 64'(log_edge[d][base+i]), 64'(e0 + i));
    end
  endtask

  initial begin
    int  t, a;
    bit  found;
    int  wn_snap;
    int  exp_c [5];

    for (int i = 0; i < 32; i++) mem[i] = 32'hA5A5_0000 + 32'(i);
    for (int d = 0; d < 3; d++) clear_log(d);

    // Reset state
    @(negedge clk);
    check("rst_we",    64'(if_a.rf_we_o), 64'd0);
    check("rst_busy",  64'(busy_a), 64'd0);
    check("rst_done",  64'(done_a), 64'd0);
    check("rst_cnt",   64'(cnt_a), 64'd0);
    check("rst_rdadr", 64'(if_a.rr_addr_o), 64'd0);
    check("rst_wd",    64'(if_a.rf_wd_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single fault pulse, x0 skipped
    clear_log(0);
    pulse_fault(0, t);
    repeat (40) @(negedge clk);
    check("t1_nwr", 64'(wn[0]), 64'd31);
    check_pass(0, "t1", 0, 1, 31, t + 2);
    check("t1_done_n",    64'(done_n[0]), 64'd1);
    check("t1_done_edge", 64'(done_edge[0]), 64'(t + 33));
    check("t1_busy_n",    64'(busy_n[0]), 64'd33);
    check("t1_cnt",       64'(cnt_a), 64'd1);

    // 2: x0 restored as well
    clear_log(1);
    pulse_fault(1, t);
    repeat (40) @(negedge clk);
    check("t2_nwr", 64'(wn[1]), 64'd32);
    check_pass(1, "t2", 0, 0, 32, t + 2);
    check("t2_x0_data",   64'(log_data[1][0]), 64'h0000_0000_A5A5_0000);
    check("t2_busy_n",    64'(busy_n[1]), 64'd34);
    check("t2_done_edge", 64'(done_edge[1]), 64'(t + 34));
    check("t2_cnt",       64'(cnt_b), 64'd1);

    // 3: second fault edge while the address-10 write is presented
    clear_log(0);
    pulse_fault(0, t);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (we[0] === 1'b1 && wa[0] == 5'd10) found = 1'b1;
    end
    check("t3_found_a10", 64'(found), 64'd1);
    set_fault(0, 1'b1);
    a = pos_cnt + 1;
    @(negedge clk);
    check("t3_abort_we", 64'(if_a.rf_we_o), 64'd0);
    set_fault(0, 1'b0);
    repeat (45) @(negedge clk);
    check("t3_abort_edge", 64'(a), 64'(t + 11));
    check("t3_nwr", 64'(wn[0]), 64'd41);
    check_pass(0, "t3a", 0, 1, 10, t + 2);
    check_pass(0, "t3b", 10, 1, 31, a + 2);
    check("t3_done_n",    64'(done_n[0]), 64'd1);
    check("t3_done_edge", 64'(done_edge[0]), 64'(a + 33));
    check("t3_cnt",       64'(cnt_a), 64'd2);

    // 5: fault held high for 100 cycles
    clear_log(0);
    @(negedge clk);
    set_fault(0, 1'b1);
    repeat (100) @(negedge clk);
    set_fault(0, 1'b0);
    repeat (40) @(negedge clk);
    check("t5_nwr",    64'(wn[0]), 64'd31);
    check("t5_done_n", 64'(done_n[0]), 64'd1);
    check("t5_cnt",    64'(cnt_a), 64'd3);

    // 6: 2-bit counter saturates at 3
    exp_c = '{1, 2, 3, 3, 3};
    clear_log(2);
    for (int r = 0; r < 5; r++) begin
      pulse_fault(2, t);
      repeat (40) @(negedge clk);
      check("t6_cnt", 64'(cnt_c), 64'(exp_c[r]));
    end
    check("t6_done_n", 64'(done_n[2]), 64'd5);

    // 4: asynchronous reset in the middle of a pass
    clear_log(0);
    pulse_fault(0, t);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (we[0] === 1'b1 && wa[0] == 5'd15) found = 1'b1;
    end
    check("t4_found_a15", 64'(found), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t4_async_we",   64'(if_a.rf_we_o), 64'd0);
    check("t4_async_busy", 64'(busy_a), 64'd0);
    check("t4_async_done", 64'(done_a), 64'd0);
    check("t4_async_cnt",  64'(cnt_a), 64'd0);
    @(negedge clk);
    wn_snap = wn[0];
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("t4_no_writes", 64'(wn[0]), 64'(wn_snap));
    check("t4_cnt",       64'(cnt_a), 64'd0);
    check("t4_busy",      64'(busy_a), 64'd0);
    check("t4_cnt_c",     64'(cnt_c), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
